// File: rtl/uart_rx_pkg.sv
// Shared UART constants: default bit divider, frame size and receiver state encoding.
// Imported by the receiver and usable by the matching transmitter.
package uart_rx_pkg;

    localparam int DEF_CLKDIV = 50000000 / 115200 - 1;
    localparam int DATA_BITS  = 8;
    localparam int DIV_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_WAITHI = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs (rx pin, GPIO inputs); resets to all ones.
// Ports: clk, rst (async active-low), i_d (async in), o_q (synchronized out).
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_ff1;
    logic [WIDTH-1:0] r_ff2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ff1 <= '1;
            r_ff2 <= '1;
        end else begin
            r_ff1 <= i_d;
            r_ff2 <= r_ff1;
        end
    end

    assign o_q = r_ff2;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples each bit at its centre, strobes good bytes, flags bad stop bits.
// Ports: clk, rst (async active-low), rx_serial, dout[7:0], dout_valid, frame_err, busy.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKDIV  = DEF_CLKDIV,
    parameter int HALFDIV = CLKDIV / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [DIV_W-1:0] W_FULL = DIV_W'(CLKDIV);
    localparam logic [DIV_W-1:0] W_HALF = DIV_W'(HALFDIV);

    logic             w_rxs;
    rx_state_t        r_state;
    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_bitcnt;
    logic [7:0]       r_shreg;
    logic [7:0]       r_dout;
    logic             r_valid;
    logic             r_ferr;

    sync_2ff #(.WIDTH(1)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx_serial),
        .o_q (w_rxs)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_div    <= '0;
            r_bitcnt <= '0;
            r_shreg  <= '0;
            r_dout   <= '0;
            r_valid  <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (!w_rxs) begin
                        r_state <= ST_START;
                        r_div   <= '0;
                    end
                end
                ST_START: begin
                    if (r_div == W_HALF) begin
                        r_div    <= '0;
                        r_bitcnt <= '0;
                        // a line that is high again at mid-start was a glitch
                        r_state  <= w_rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_div == W_FULL) begin
                        r_div   <= '0;
                        r_shreg <= {w_rxs, r_shreg[7:1]};
                        if (r_bitcnt == 3'(DATA_BITS - 1)) begin
                            r_state <= ST_STOP;
                        end
                        r_bitcnt <= r_bitcnt + 1'b1;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_div == W_FULL) begin
                        r_div <= '0;
                        if (w_rxs) begin
                            r_dout  <= r_shreg;
                            r_valid <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= ST_WAITHI;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                ST_WAITHI: begin
                    // swallow a break until the line idles high again
                    if (w_rxs) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign frame_err  = r_ferr;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with CLKDIV=15 (16 clocks per bit, clock period 100 units).
// A behavioural sender drives rx_serial with arbitrary bit periods in time units.
module tb_uart_rx;

    localparam int BT = 1600;

    logic       clk;
    logic       rst;
    logic       rx_serial;
    logic [7:0] dout;
    logic       dout_valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;
    int fcnt   = 0;
    int both   = 0;
    logic [7:0] q[$];

    uart_rx #(.CLKDIV(15), .HALFDIV(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_serial  (rx_serial),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    always @(negedge clk) begin
        if (dout_valid) begin
            vcnt = vcnt + 1;
            q.push_back(dout);
        end
        if (frame_err) fcnt = fcnt + 1;
        if (dout_valid && frame_err) both = both + 1;
    end

    task automatic send_frame(input logic [7:0] b, input int bt,
                              input logic stopv);
        rx_serial = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            #(bt);
        end
        rx_serial = stopv;
        #(bt);
        rx_serial = 1'b1;
    endtask

    task automatic clear_mon();
        vcnt = 0;
        fcnt = 0;
        q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rx_serial = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout: got %h want 00", dout);
        end
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", dout_valid);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ferr: got %b want 0", frame_err);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_loopback();
        clear_mon();
        @(negedge clk);
        send_frame(8'hA5, BT, 1'b1);
        #(2 * BT);
        checks++;
        if (vcnt != 1) begin
            errors++;
            $display("FAIL loop_count: got %0d want 1", vcnt);
        end
        checks++;
        if (dout !== 8'hA5) begin
            errors++;
            $display("FAIL loop_dout: got %h want a5", dout);
        end
        checks++;
        if (fcnt != 0) begin
            errors++;
            $display("FAIL loop_ferr: got %0d want 0", fcnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL loop_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [4];
        exp = '{8'h00, 8'hFF, 8'h55, 8'h3C};
        clear_mon();
        @(negedge clk);
        for (int i = 0; i < 4; i++) send_frame(exp[i], BT, 1'b1);
        #(2 * BT);
        checks++;
        if (vcnt != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 4", vcnt);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q.size() <= i) begin
                errors++;
                $display("FAIL b2b_byte%0d: got none want %h", i, exp[i]);
            end else if (q[i] !== exp[i]) begin
                errors++;
                $display("FAIL b2b_byte%0d: got %h want %h", i, q[i], exp[i]);
            end
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        @(negedge clk);
        rx_serial = 1'b0;
        repeat (4) @(negedge clk);
        rx_serial = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_start: busy got %b want 1", busy);
        end
        #(2 * BT);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_idle: busy got %b want 0", busy);
        end
        checks++;
        if (vcnt != 0) begin
            errors++;
            $display("FAIL glitch_valid: got %0d want 0", vcnt);
        end
        checks++;
        if (fcnt != 0) begin
            errors++;
            $display("FAIL glitch_ferr: got %0d want 0", fcnt);
        end
    endtask

    task automatic test_frame_err();
        clear_mon();
        @(negedge clk);
        send_frame(8'h81, BT, 1'b0);
        rx_serial = 1'b0;
        #(3 * BT);
        rx_serial = 1'b1;
        #(2 * BT);
        checks++;
        if (fcnt != 1) begin
            errors++;
            $display("FAIL ferr_count: got %0d want 1", fcnt);
        end
        checks++;
        if (vcnt != 0) begin
            errors++;
            $display("FAIL ferr_valid: got %0d want 0", vcnt);
        end
        checks++;
        if (dout !== 8'h3C) begin
            errors++;
            $display("FAIL ferr_hold: got %h want 3c", dout);
        end
        @(negedge clk);
        send_frame(8'h42, BT, 1'b1);
        #(2 * BT);
        checks++;
        if (vcnt != 1 || dout !== 8'h42) begin
            errors++;
            $display("FAIL ferr_next: got %0d/%h want 1/42", vcnt, dout);
        end
        checks++;
        if (fcnt != 1) begin
            errors++;
            $display("FAIL ferr_once: got %0d want 1", fcnt);
        end
    endtask

    task automatic test_reset_midframe();
        clear_mon();
        @(negedge clk);
        fork
            send_frame(8'hF0, BT, 1'b1);
        join_none
        #(5 * BT + BT / 2);
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || dout !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_now: busy/dout got %b/%h want 0/00",
                     busy, dout);
        end
        checks++;
        if (dout_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_strobe: got %b/%b want 0/0",
                     dout_valid, frame_err);
        end
        #299;
        rst = 1'b1;
        wait fork;
        #(2 * BT);
        checks++;
        if (vcnt != 0 || fcnt != 0) begin
            errors++;
            $display("FAIL rstmid_none: got %0d/%0d want 0/0", vcnt, fcnt);
        end
        @(negedge clk);
        send_frame(8'h0F, BT, 1'b1);
        #(2 * BT);
        checks++;
        if (vcnt != 1 || dout !== 8'h0F) begin
            errors++;
            $display("FAIL rstmid_next: got %0d/%h want 1/0f", vcnt, dout);
        end
    endtask

    task automatic test_tolerance();
        int bts [4];
        bts = '{BT + 32, BT - 32, 1700, 1500};
        for (int k = 0; k < 4; k++) begin
            clear_mon();
            @(negedge clk);
            send_frame(8'hC3, bts[k], 1'b1);
            #(2 * BT);
            checks++;
            if (vcnt != 1 || dout !== 8'hC3) begin
                errors++;
                $display("FAIL tol_bt%0d: got %0d/%h want 1/c3",
                         bts[k], vcnt, dout);
            end
            checks++;
            if (fcnt != 0) begin
                errors++;
                $display("FAIL tol_ferr_bt%0d: got %0d want 0", bts[k], fcnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_midframe();
        test_tolerance();
        checks++;
        if (both != 0) begin
            errors++;
            $display("FAIL valid_and_ferr: got %0d want 0", both);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
